// File: rtl/x_skew_buffer.sv
// Multi-lane X-edge staging buffer: per-lane register files filled by index, then
// streamed out with lane k delayed by k*SKEW enabled cycles. Consumed slots are zero-filled.
module x_skew_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   parameter int LANES  = 4,
   parameter int SKEW   = 1,
   localparam int IW = $clog2(DEPTH),
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int CW = $clog2(DEPTH + (LANES - 1) * SKEW + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    write,
   input  logic [LW-1:0]           lane,
   input  logic [IW-1:0]           idx,
   input  logic [DATA_W-1:0]       din,
   input  logic                    start,
   input  logic [IW:0]             len,
   output logic [LANES*DATA_W-1:0] dout,
   output logic [LANES-1:0]        dvalid,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   mem [LANES][DEPTH];
   logic [IW:0]         len_lat;
   logic [IW:0]         len_min;
   logic [CW-1:0]       cnt;
   logic [CW:0]         last_c;
   logic                stream_end;
   logic [LANES-1:0]    active;

   assign len_min    = (len > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : len;
   // Only meaningful in STREAM, where len_lat is at least 1.
   assign last_c     = (CW+1)'(len_lat) + (CW+1)'((LANES - 1) * SKEW) - (CW+1)'(1);
   assign stream_end = (state == S_STREAM) && ({1'b0, cnt} == last_c);
   assign busy       = (state == S_STREAM);

   always_comb begin
      active = '0;
      for (int k = 0; k < LANES; k++) begin
         active[k] = (int'(cnt) >= k * SKEW) && (int'(cnt) < k * SKEW + int'(len_lat));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (en && start && !write && (len_min != '0)) state_nxt = S_STREAM;
         S_STREAM: if (en && stream_end) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LANES; k++)
            for (int i = 0; i < DEPTH; i++)
               mem[k][i] <= '0;
         dout    <= '0;
         dvalid  <= '0;
         done    <= 1'b0;
         cnt     <= '0;
         len_lat <= '0;
      end else if (en) begin
         if (state == S_IDLE) begin
            dout   <= '0;
            dvalid <= '0;
            done   <= 1'b0;
            if (write) begin
               if (int'(lane) < LANES) mem[lane][idx] <= din;
            end else if (start) begin
               len_lat <= len_min;
               cnt     <= '0;
               // A zero-length stream never enters STREAM; it just acknowledges.
               if (len_min == '0) done <= 1'b1;
            end
         end else begin
            for (int k = 0; k < LANES; k++) begin
               if (active[k]) begin
                  dout[k*DATA_W +: DATA_W] <= mem[k][0];
                  for (int i = 0; i < DEPTH - 1; i++) mem[k][i] <= mem[k][i+1];
                  mem[k][DEPTH-1] <= '0;
                  dvalid[k]       <= 1'b1;
               end else begin
                  dout[k*DATA_W +: DATA_W] <= '0;
                  dvalid[k]                <= 1'b0;
               end
            end
            cnt  <= cnt + CW'(1);
            done <= stream_end;
         end
      end
   end

endmodule

// File: doc/x_skew_buffer.md
# x_skew_buffer

Multi-lane, parametrised input staging buffer for the systolic array's X (activation) edge. Each lane is an addressable register file that is filled by absolute index, then streamed out one element per enabled cycle. Lane k is delayed by k·SKEW cycles, so the array receives diagonally skewed wavefronts without external delay lines. Consumed slots are zero-filled, and a DONE pulse marks the end of each stream.

## Interface
- DATA_W, 8: element width in bits
- DEPTH, 32: entries per lane
- LANES, 4: number of lanes (array rows)
- SKEW, 1: extra delay per lane index, in enabled cycles (0 = no stagger)
- CLK  in  1  sole clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- EN  in  1  global enable; low = full stall (no state, counter or output change)
- WRITE  in  1  write strobe (IDLE only)
- LANE  in  $clog2(LANES)  lane written
- IDX  in  $clog2(DEPTH)  absolute entry index written
- DIN  in  DATA_W  write data
- START  in  1  begin stream (IDLE only)
- LEN  in  $clog2(DEPTH)+1  elements per lane to stream, 0..DEPTH
- DOUT  out  LANES·DATA_W  lane k occupies bits [k·DATA_W +: DATA_W]; registered
- DVALID  out  LANES  per-lane valid; registered
- BUSY  out  1  high in STREAM
- DONE  out  1  one-cycle pulse at the end of a stream

## Operation
- States: IDLE, STREAM.
- All actions occur only on edges where EN = 1.
- IDLE, WRITE = 1: MEM[LANE][IDX] <= DIN.
  - LANE ≥ LANES: the write is dropped.
  - WRITE has priority; START in the same cycle is ignored.
- IDLE, START = 1, WRITE = 0:
  - Latch L = min(LEN, DEPTH).
  - Clear cycle counter C to 0.
  - Go to STREAM.
  - L = 0: stay IDLE, pulse DONE next edge, no DVALID.
- STREAM, each enabled edge with counter value C, for each lane k:
  - Active when k·SKEW ≤ C < k·SKEW + L.
  - Active lane: DOUT[k] <= MEM[k][0]; MEM[k][i] <= MEM[k][i+1]; MEM[k][DEPTH-1] <= 0; DVALID[k] <= 1.
  - Inactive lane: DOUT[k] <= 0; DVALID[k] <= 0; memory unchanged.
  - Then C <= C + 1.
- End of stream: the edge where C = L + (LANES-1)·SKEW - 1.
  - That edge sets DONE <= 1 and goes to IDLE (BUSY <= 0).
  - The next enabled edge clears DONE, DVALID and DOUT.
- Counter width: $clog2(DEPTH + (LANES-1)·SKEW + 1); must not wrap.
- WRITE and START in STREAM are ignored.
- After a full-depth stream (L = DEPTH), every lane is all-zero.
- After a partial stream (L < DEPTH), unread entries sit shifted down by L.
- DONE, DVALID and DOUT hold their values while EN = 0.

## Timing
- Reset values: every MEM entry 0, state IDLE, C = 0, DOUT = 0, DVALID = 0, BUSY = 0, DONE = 0.
- RST mid-stream aborts immediately. The buffer is then empty, not resumable.
- Write latency: data written at edge t is streamable by a START sampled at edge t+1.
- Stream timing, with START sampled at edge S (EN always high):
  - BUSY is high after S.
  - Lane k's first valid element appears after edge S+1+k·SKEW.
  - Lane k's last valid element appears after edge S+k·SKEW+L.
  - DONE and BUSY = 0 appear after edge S+L+(LANES-1)·SKEW, coincident with the last valid element of lane LANES-1.
- Back-to-back streams: the earliest next START is sampled on the edge after DONE rises.
- EN-low cycles stretch every count above by one cycle each.

## Test plan
1. Reset and fill:
   - Stimulus: assert RST mid-idle, then write lane0 = 1..4 at IDX 0..3 and lane1 = 0x11..0x14.
   - Response: all outputs 0 during reset; MEM readback via stream matches.
2. Skewed stream, LANES=4, SKEW=1, L=4, each lane k preloaded with 0x10·k + (0..3):
   - Lane0 is valid after edges S+1..S+4; lane3 after S+4..S+7.
   - DONE is high only after S+7; lanes carry no duplicate or stray values.
3. Stall: same as test 2 with EN dropped for 3 cycles after edge S+2.
   - Outputs freeze; DONE moves to S+10; the data sequence is unchanged.
4. Edge cases:
   - LEN = 0: DONE pulse one cycle after START; DVALID stays 0.
   - LEN = DEPTH = 32: 32 valid elements per lane, then a second stream outputs all zeros.
5. Ignored inputs and priority:
   - WRITE and START asserted during STREAM are ignored: contents and timing unchanged.
   - WRITE and START asserted together in IDLE: the write lands, the stream does not start.
   - A write to LANE ≥ LANES is dropped, which matters when LANES is not a power of 2.
6. Reset mid-stream:
   - Stimulus: RST at S+3.
   - Response: BUSY, DONE, DVALID and DOUT go to 0 asynchronously. A subsequent START with L=4 streams zeros.
